// File: rtl/id_pkg.sv
// Shared decode definitions for the ID stage: opcodes, ALU op classes and
// the control bundle carried across the ID/EX boundary.
package id_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [1:0] ALU_ADD    = 2'b00;
  localparam logic [1:0] ALU_BRANCH = 2'b01;
  localparam logic [1:0] ALU_FUNCT  = 2'b10;

  typedef struct packed {
    logic       branch;
    logic       mem_read;
    logic       mem_to_reg;
    logic       mem_write;
    logic       alu_src;
    logic       reg_write;
    logic [1:0] alu_op;
    logic       illegal;
  } ctrl_t;

endpackage

// File: rtl/regfile_bypass.sv
// NREG x XLEN register file, one write port and two read ports; a read of the
// register being written this cycle returns the incoming data.
module regfile_bypass #(
  parameter int XLEN = 8,
  parameter int NREG = 32,
  localparam int RW  = $clog2(NREG)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            we,
  input  logic [RW-1:0]   waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [RW-1:0]   raddr1,
  input  logic [RW-1:0]   raddr2,
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] rdata2
);

  logic [NREG-1:0][XLEN-1:0] mem;
  logic                      wr_en;

  assign wr_en = we && (waddr != '0);

  always_ff @(posedge clock or posedge reset) begin
    if (reset)      mem <= '0;
    else if (wr_en) mem[waddr] <= wdata;
  end

  // x0 is hardwired; the write enable already excludes it from the bypass
  assign rdata1 = (raddr1 == '0) ? '0 : (wr_en && waddr == raddr1) ? wdata : mem[raddr1];
  assign rdata2 = (raddr2 == '0) ? '0 : (wr_en && waddr == raddr2) ? wdata : mem[raddr2];

endmodule

// File: rtl/id_stage_pipelined.sv
// RISC-V instruction decode stage: control decode, register read with
// write-back bypass, immediate generation, load-use stall and ID/EX register.
module id_stage_pipelined
  import id_pkg::*;
#(
  parameter int XLEN  = 8,
  parameter int NREG  = 32,
  parameter int IMM_W = 12,
  localparam int RW   = $clog2(NREG)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instruction,
  input  logic             flush,
  input  logic             ex_mem_read,
  input  logic [RW-1:0]    ex_rd,
  input  logic             wb_valid,
  input  logic [RW-1:0]    wb_rd,
  input  logic [XLEN-1:0]  wb_data,
  output logic             stall,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             branch,
  output logic             mem_read,
  output logic             mem_to_reg,
  output logic             mem_write,
  output logic             alu_src,
  output logic             reg_write,
  output logic [1:0]       alu_op,
  output logic             illegal,
  output logic [XLEN-1:0]  read_data1,
  output logic [XLEN-1:0]  read_data2,
  output logic [IMM_W-1:0] immediate,
  output logic [9:0]       funct,
  output logic [RW-1:0]    rd
);

  logic [6:0]      opcode;
  logic [RW-1:0]   rs1, rs2, rd_dec;
  logic [XLEN-1:0] rdata1, rdata2;
  logic [11:0]     imm12;
  logic            uses_rs2;
  logic            accept;
  ctrl_t           ctrl_dec, ctrl_q;

  assign opcode = instruction[6:0];
  assign rs1    = instruction[15 +: RW];
  assign rs2    = instruction[20 +: RW];
  assign rd_dec = instruction[7 +: RW];

  always_comb begin
    ctrl_dec = '0;
    imm12    = '0;
    uses_rs2 = 1'b0;
    unique case (opcode)
      OP_R: begin
        ctrl_dec.reg_write = 1'b1;
        ctrl_dec.alu_op    = ALU_FUNCT;
        uses_rs2           = 1'b1;
      end
      OP_IMM: begin
        ctrl_dec.alu_src   = 1'b1;
        ctrl_dec.reg_write = 1'b1;
        ctrl_dec.alu_op    = ALU_FUNCT;
        imm12              = instruction[31:20];
      end
      OP_LOAD: begin
        ctrl_dec.alu_src    = 1'b1;
        ctrl_dec.mem_read   = 1'b1;
        ctrl_dec.mem_to_reg = 1'b1;
        ctrl_dec.reg_write  = 1'b1;
        ctrl_dec.alu_op     = ALU_ADD;
        imm12               = instruction[31:20];
      end
      OP_STORE: begin
        ctrl_dec.alu_src   = 1'b1;
        ctrl_dec.mem_write = 1'b1;
        ctrl_dec.alu_op    = ALU_ADD;
        uses_rs2           = 1'b1;
        imm12              = {instruction[31:25], instruction[11:7]};
      end
      OP_BRANCH: begin
        ctrl_dec.branch = 1'b1;
        ctrl_dec.alu_op = ALU_BRANCH;
        uses_rs2        = 1'b1;
        imm12           = {instruction[31], instruction[7], instruction[30:25], instruction[11:8]};
      end
      default: ctrl_dec.illegal = 1'b1;
    endcase
  end

  // rs2 only counts toward the hazard for formats that actually read it
  assign stall    = in_valid && ex_mem_read && (ex_rd != '0) &&
                    ((ex_rd == rs1) || ((ex_rd == rs2) && uses_rs2));
  assign in_ready = (!out_valid || out_ready) && !stall;
  assign accept   = in_valid && in_ready;

  regfile_bypass #(.XLEN(XLEN), .NREG(NREG)) u_rf (
    .clock  (clock),
    .reset  (reset),
    .we     (wb_valid),
    .waddr  (wb_rd),
    .wdata  (wb_data),
    .raddr1 (rs1),
    .raddr2 (rs2),
    .rdata1 (rdata1),
    .rdata2 (rdata2)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_valid  <= 1'b0;
      ctrl_q     <= '0;
      read_data1 <= '0;
      read_data2 <= '0;
      immediate  <= '0;
      funct      <= '0;
      rd         <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid  <= 1'b1;
      ctrl_q     <= ctrl_dec;
      read_data1 <= rdata1;
      read_data2 <= rdata2;
      immediate  <= IMM_W'($signed(imm12));
      funct      <= {instruction[31:25], instruction[14:12]};
      rd         <= rd_dec;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign branch     = ctrl_q.branch;
  assign mem_read   = ctrl_q.mem_read;
  assign mem_to_reg = ctrl_q.mem_to_reg;
  assign mem_write  = ctrl_q.mem_write;
  assign alu_src    = ctrl_q.alu_src;
  assign reg_write  = ctrl_q.reg_write;
  assign alu_op     = ctrl_q.alu_op;
  assign illegal    = ctrl_q.illegal;

endmodule

// File: tb/tb_id_stage_pipelined.sv
// Bench for id_stage_pipelined: directed scenarios followed by random traffic,
// all checked against a cycle-level reference model of the decode stage.
module tb_id_stage_pipelined;

  localparam int XLEN  = 8;
  localparam int NREG  = 32;
  localparam int RW    = 5;
  localparam int IMM_W = 12;

  logic             clock = 1'b0;
  logic             reset;
  logic             in_valid, in_ready, flush, ex_mem_read, wb_valid, stall, out_valid, out_ready;
  logic [31:0]      instruction;
  logic [RW-1:0]    ex_rd, wb_rd, rd;
  logic [XLEN-1:0]  wb_data, read_data1, read_data2;
  logic             branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write, illegal;
  logic [1:0]       alu_op;
  logic [IMM_W-1:0] immediate;
  logic [9:0]       funct;

  always #5 clock = ~clock;

  id_stage_pipelined #(.XLEN(XLEN), .NREG(NREG), .IMM_W(IMM_W)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .instruction(instruction), .flush(flush), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .stall(stall),
    .out_valid(out_valid), .out_ready(out_ready), .branch(branch), .mem_read(mem_read),
    .mem_to_reg(mem_to_reg), .mem_write(mem_write), .alu_src(alu_src), .reg_write(reg_write),
    .alu_op(alu_op), .illegal(illegal), .read_data1(read_data1), .read_data2(read_data2),
    .immediate(immediate), .funct(funct), .rd(rd)
  );

  int checks = 0;
  int errors = 0;

  // reference model state: architectural registers and the ID/EX contents
  logic [XLEN-1:0]  rf_m [NREG];
  bit               e_valid;
  bit [5:0]         e_ctl;   // {branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write}
  bit [1:0]         e_aluop;
  bit               e_ill;
  bit [XLEN-1:0]    e_r1, e_r2;
  bit [IMM_W-1:0]   e_imm;
  bit [9:0]         e_funct;
  bit [RW-1:0]      e_rd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit reads_rs2(input logic [6:0] op);
    return (op == 7'h33) || (op == 7'h23) || (op == 7'h63);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NREG; i++) rf_m[i] = '0;
    e_valid = 0; e_ctl = 0; e_aluop = 0; e_ill = 0;
    e_r1 = 0; e_r2 = 0; e_imm = 0; e_funct = 0; e_rd = 0;
  endtask

  // decode straight from the opcode table; immediates built by shifting the word
  task automatic model_decode(input logic [31:0] w);
    int sw;
    sw = int'(w);
    e_ill = 0; e_imm = 0;
    case (w[6:0])
      7'h33: begin e_ctl = 6'b000001; e_aluop = 2; end
      7'h13: begin e_ctl = 6'b000011; e_aluop = 2; e_imm = IMM_W'(sw >>> 20); end
      7'h03: begin e_ctl = 6'b011011; e_aluop = 0; e_imm = IMM_W'(sw >>> 20); end
      7'h23: begin e_ctl = 6'b000110; e_aluop = 0;
                   e_imm = IMM_W'(((sw >>> 25) * 32) + int'(w[11:7])); end
      7'h63: begin e_ctl = 6'b100000; e_aluop = 1;
                   e_imm = IMM_W'(((sw >>> 31) * 2048) + int'(w[7]) * 1024
                                  + int'(w[30:25]) * 16 + int'(w[11:8])); end
      default: begin e_ctl = 0; e_aluop = 0; e_ill = 1; end
    endcase
    e_funct = {w[31:25], w[14:12]};
    e_rd    = w[11:7];
  endtask

  task automatic check_out();
    chk("out_valid", out_valid, e_valid);
    if (e_valid) begin
      chk("ctrl", {branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write}, e_ctl);
      chk("alu_op", alu_op, e_aluop);
      chk("illegal", illegal, e_ill);
      chk("read_data1", read_data1, e_r1);
      chk("read_data2", read_data2, e_r2);
      chk("immediate", immediate, e_imm);
      chk("funct", funct, e_funct);
      chk("rd", rd, e_rd);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_valid"}, out_valid, 0);
    chk({tag, "_ctrl"}, {branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write, alu_op, illegal}, 0);
    chk({tag, "_data"}, {read_data1, read_data2}, 0);
    chk({tag, "_imm"}, {immediate, funct, rd}, 0);
  endtask

  // inputs are already driven; check handshake, advance model and DUT one edge
  task automatic cycle();
    bit st, rdy;
    logic [XLEN-1:0] nrf [NREG];
    logic [4:0] r1, r2;
    #1;
    r1 = instruction[19:15];
    r2 = instruction[24:20];
    st  = in_valid && ex_mem_read && ex_rd != 0 &&
          (ex_rd == r1 || (ex_rd == r2 && reads_rs2(instruction[6:0])));
    rdy = (!e_valid || out_ready) && !st;
    chk("stall", stall, st);
    chk("in_ready", in_ready, rdy);
    nrf = rf_m;
    if (wb_valid && wb_rd != 0) nrf[wb_rd] = wb_data;
    if (flush) e_valid = 0;
    else if (in_valid && rdy) begin
      model_decode(instruction);
      e_r1 = nrf[r1];
      e_r2 = nrf[r2];
      e_valid = 1;
    end else if (out_ready) e_valid = 0;
    rf_m = nrf;
    @(posedge clock); #1;
    check_out();
  endtask

  task automatic idle();
    in_valid = 0; instruction = 0; flush = 0; ex_mem_read = 0; ex_rd = 0;
    wb_valid = 0; wb_rd = 0; wb_data = 0; out_ready = 1;
  endtask

  logic [31:0] snap;
  logic [31:0] w;
  int pick;

  initial begin
    reset = 1;
    idle();
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    check_zero("reset");
    reset = 0;

    // 1: write x5 then addi x6,x5,-1
    wb_valid = 1; wb_rd = 5; wb_data = 8'h3C;
    cycle();
    wb_valid = 0; in_valid = 1; instruction = 32'hFFF28313;
    cycle();
    chk("t1_valid", out_valid, 1);
    chk("t1_rd1", read_data1, 8'h3C);
    chk("t1_imm", immediate, 12'hFFF);
    chk("t1_ctl", {alu_src, reg_write}, 2'b11);
    chk("t1_rd", rd, 6);

    // 2: add x8,x7,x0 with concurrent write-back of x7
    wb_valid = 1; wb_rd = 7; wb_data = 8'hA5; instruction = 32'h00038433;
    cycle();
    chk("t2_rd1", read_data1, 8'hA5);
    chk("t2_rd2", read_data2, 0);
    wb_valid = 0;

    // 3: sw x3,4(x2) behind a load to x3, then the same with ex_rd=0
    ex_mem_read = 1; ex_rd = 3; instruction = 32'h00312223;
    #1;
    chk("t3_stall", stall, 1);
    chk("t3_in_ready", in_ready, 0);
    cycle();
    chk("t3_bubble", out_valid, 0);
    ex_rd = 0;
    #1;
    chk("t3_nostall", stall, 0);
    cycle();
    chk("t3_imm", immediate, 4);
    ex_mem_read = 0;

    // 4: back-pressure holds ID/EX for three cycles
    out_ready = 0; instruction = 32'h0041A283;
    snap = {read_data1, read_data2, immediate, funct[3:0]};
    repeat (3) begin
      cycle();
      chk("t4_hold", {read_data1, read_data2, immediate, funct[3:0]}, snap);
      chk("t4_in_ready", in_ready, 0);
    end
    out_ready = 1;
    cycle();
    chk("t4_load", mem_read, 1);

    // 5: flush discards beq while a write-back to x9 still lands
    flush = 1; instruction = 32'h00208063; wb_valid = 1; wb_rd = 9; wb_data = 8'h5A;
    cycle();
    chk("t5_flush", out_valid, 0);
    flush = 0; wb_valid = 0; instruction = 32'h00948533;
    cycle();
    chk("t5_rd1", read_data1, 8'h5A);
    chk("t5_rd2", read_data2, 8'h5A);

    // 6: illegal opcode, then write to x0 is ignored
    instruction = 32'h0000007F;
    cycle();
    chk("t6_illegal", illegal, 1);
    chk("t6_ctl", {branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write, alu_op}, 0);
    wb_valid = 1; wb_rd = 0; wb_data = 8'hFF; instruction = 32'h000005B3;
    cycle();
    chk("t6_x0", read_data1, 0);
    wb_valid = 0;

    // random traffic
    for (int n = 0; n < 400; n++) begin
      w = $urandom;
      pick = $urandom_range(0, 5);
      case (pick)
        0: w[6:0] = 7'h33;
        1: w[6:0] = 7'h13;
        2: w[6:0] = 7'h03;
        3: w[6:0] = 7'h23;
        4: w[6:0] = 7'h63;
        default: w[6:0] = 7'($urandom);
      endcase
      w[19:15] = 5'($urandom_range(0, 7));
      w[24:20] = 5'($urandom_range(0, 7));
      instruction = w;
      in_valid    = ($urandom_range(0, 3) != 0);
      out_ready   = ($urandom_range(0, 3) != 0);
      flush       = ($urandom_range(0, 15) == 0);
      ex_mem_read = ($urandom_range(0, 3) == 0);
      ex_rd       = 5'($urandom_range(0, 7));
      wb_valid    = ($urandom_range(0, 1) == 1);
      wb_rd       = 5'($urandom_range(0, 7));
      wb_data     = 8'($urandom);
      cycle();
    end

    // asynchronous reset mid-stream clears everything before the next edge
    in_valid = 1; out_ready = 1; flush = 0; ex_mem_read = 0; wb_valid = 0;
    instruction = 32'h00A00313;
    cycle();
    reset = 1;
    #1;
    check_zero("async_reset");
    model_reset();
    #1;
    reset = 0;
    instruction = 32'h00728433;   // add x8,x5,x7 -> both cleared
    cycle();
    chk("post_reset_rd1", read_data1, 0);
    idle();
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
